// File: rtl/blk64_sram_writer.sv
// Buffers an 8x8 block of DW-bit words and streams it to SRAM in row-major order
// with a valid/ready write handshake, then pulses done for one cycle.
module blk64_sram_writer #(
    parameter int AW = 18,
    parameter int DW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic          ld_en,
    input  logic [5:0]    ld_addr,
    input  logic [DW-1:0] ld_data,
    input  logic          sram_ready,
    output logic          sram_we,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_data,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [5:0]    k, k_nxt;
    logic [AW-1:0] base, base_nxt;
    logic [DW-1:0] buffer [64];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            k     <= 6'd0;
            base  <= '0;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
            base  <= base_nxt;
        end
    end

    // Buffer has no reset; loads are locked out while a transfer reads it.
    always_ff @(posedge clock) begin
        if (ld_en && (state != WRITE)) begin
            buffer[ld_addr] <= ld_data;
        end
    end

    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        base_nxt  = base;
        sram_we   = 1'b0;
        sram_addr = '0;
        sram_data = '0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = WRITE;
                    base_nxt  = base_addr;
                    k_nxt     = 6'd0;
                end
            end
            WRITE: begin
                sram_we   = 1'b1;
                busy      = 1'b1;
                sram_addr = base + AW'(k);
                sram_data = buffer[k];
                // Address wraps silently; k wraps to 0 after the last word.
                if (sram_ready) begin
                    k_nxt = k + 6'd1;
                    if (k == 6'd63) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_blk64_sram_writer.sv
// Self-checking bench for blk64_sram_writer: table-driven loads, directed
// handshake/wrap/reset sequences and a random phase against a queue model.
module tb_blk64_sram_writer;

    localparam int AW = 18;
    localparam int DW = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          ld_en = 1'b0;
    logic [5:0]    ld_addr = '0;
    logic [DW-1:0] ld_data = '0;
    logic          sram_ready = 1'b0;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_data;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;
    int dut_writes = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        logic          st;
        logic          le;
        logic [5:0]    la;
        logic [DW-1:0] ld;
        logic          rdy;
        logic          exp_we;
        logic          exp_busy;
        logic          exp_done;
    } vec_t;

    wr_t           exp_q[$];
    logic [DW-1:0] model_buf [64];
    bit            model_done = 1'b0;

    blk64_sram_writer #(.AW(AW), .DW(DW)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .sram_ready (sram_ready),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_data  (sram_data),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // A pending transfer is a queue of the 64 writes still owed; done follows the last pop.
    task automatic modelEdge();
        wr_t w;
        if (exp_q.size() != 0) begin
            if (sram_ready) begin
                exp_q.delete(0);
                if (exp_q.size() == 0) model_done = 1'b1;
            end
        end else if (model_done) begin
            model_done = 1'b0;
            if (ld_en) model_buf[ld_addr] = ld_data;
        end else begin
            if (ld_en) model_buf[ld_addr] = ld_data;
            if (start) begin
                for (int i = 0; i < 64; i++) begin
                    w.addr = base_addr + AW'(i);
                    w.data = model_buf[i];
                    exp_q.push_back(w);
                end
            end
        end
    endtask

    task automatic checkModel();
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        e_we   = (exp_q.size() != 0);
        e_addr = e_we ? exp_q[0].addr : '0;
        e_data = e_we ? exp_q[0].data : '0;
        checkOutput("sram_we", 32'(sram_we), 32'(e_we));
        checkOutput("busy", 32'(busy), 32'(e_we));
        checkOutput("done", 32'(done), 32'(model_done));
        checkOutput("sram_addr", 32'(sram_addr), 32'(e_addr));
        checkOutput("sram_data", 32'(sram_data), 32'(e_data));
    endtask

    task automatic applyStimulus(input logic st, input logic [AW-1:0] ba, input logic le,
                                 input logic [5:0] la, input logic [DW-1:0] ld, input logic rdy);
        start      = st;
        base_addr  = ba;
        ld_en      = le;
        ld_addr    = la;
        ld_data    = ld;
        sram_ready = rdy;
        if (sram_we && sram_ready) dut_writes++;
        @(posedge clock);
        modelEdge();
        #1;
        checkModel();
    endtask

    task automatic idleCycle(input logic rdy);
        applyStimulus(1'b0, '0, 1'b0, 6'd0, '0, rdy);
    endtask

    // Asserts reset mid-cycle so the outputs must drop without waiting for a clock edge.
    task automatic doReset();
        start  = 1'b0;
        ld_en  = 1'b0;
        reset  = 1'b1;
        #1;
        checkOutput("rst_we", 32'(sram_we), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_addr", 32'(sram_addr), 32'd0);
        checkOutput("rst_data", 32'(sram_data), 32'd0);
        exp_q.delete();
        model_done = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        vec_t vecs[$];
        vec_t v;
        int   n;
        int   cnt;
        int   done_at;
        int   hold_cnt;
        int   xfer_cnt;
        int   writes0;
        int   rise1;
        int   rise2;
        logic prev_we;

        for (int i = 0; i < 64; i++) begin
            v.st = 1'b0; v.le = 1'b1; v.la = 6'(i); v.ld = 16'h1000 + 16'(i);
            v.rdy = 1'(i); v.exp_we = 1'b0; v.exp_busy = 1'b0; v.exp_done = 1'b0;
            vecs.push_back(v);
        end
        for (int i = 0; i < 4; i++) begin
            v.st = 1'b0; v.le = 1'b0; v.la = 6'd0; v.ld = 16'h0;
            v.rdy = 1'b1; v.exp_we = 1'b0; v.exp_busy = 1'b0; v.exp_done = 1'b0;
            vecs.push_back(v);
        end

        #2;
        doReset();

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].st, '0, vecs[i].le, vecs[i].la, vecs[i].ld, vecs[i].rdy);
            checkOutput("vec_we", 32'(sram_we), 32'(vecs[i].exp_we));
            checkOutput("vec_busy", 32'(busy), 32'(vecs[i].exp_busy));
            checkOutput("vec_done", 32'(done), 32'(vecs[i].exp_done));
        end

        $display("[TB] basic transfer, ready always high");
        applyStimulus(1'b1, 18'h00100, 1'b0, 6'd0, '0, 1'b1);
        cnt = 0; done_at = -1;
        for (n = 1; n <= 70; n++) begin
            if (sram_we) cnt++;
            if (done) done_at = n;
            if (n == 1) begin
                checkOutput("s1_first_addr", 32'(sram_addr), 32'h00100);
                checkOutput("s1_first_data", 32'(sram_data), 32'h1000);
            end
            if (n == 64) begin
                checkOutput("s1_last_addr", 32'(sram_addr), 32'h0013F);
                checkOutput("s1_last_data", 32'(sram_data), 32'h103F);
            end
            idleCycle(1'b1);
        end
        checkOutput("s1_we_cycles", 32'(cnt), 32'd64);
        checkOutput("s1_done_cycle", 32'(done_at), 32'd65);

        $display("[TB] stall at k=10");
        applyStimulus(1'b1, 18'h00100, 1'b0, 6'd0, '0, 1'b1);
        hold_cnt = 0; xfer_cnt = 0; done_at = -1;
        for (n = 1; n <= 75; n++) begin
            if (done) done_at = n;
            if (sram_we && sram_addr == 18'h0010A) begin
                hold_cnt++;
                checkOutput("s2_hold_data", 32'(sram_data), 32'h100A);
            end
            if (n >= 11 && n <= 13) begin
                idleCycle(1'b0);
            end else begin
                if (sram_we && sram_addr == 18'h0010A) xfer_cnt++;
                idleCycle(1'b1);
            end
        end
        checkOutput("s2_hold_cycles", 32'(hold_cnt), 32'd4);
        checkOutput("s2_transfers_k10", 32'(xfer_cnt), 32'd1);
        checkOutput("s2_done_cycle", 32'(done_at), 32'd68);

        $display("[TB] address wrap");
        applyStimulus(1'b1, 18'h3FFFE, 1'b0, 6'd0, '0, 1'b1);
        for (n = 1; n <= 70; n++) begin
            if (n == 1) checkOutput("s3_k0_addr", 32'(sram_addr), 32'h3FFFE);
            if (n == 2) checkOutput("s3_k1_addr", 32'(sram_addr), 32'h3FFFF);
            if (n == 3) checkOutput("s3_k2_addr", 32'(sram_addr), 32'h00000);
            idleCycle(1'b1);
        end

        $display("[TB] start and load ignored during transfer");
        writes0 = dut_writes;
        applyStimulus(1'b1, 18'h02000, 1'b0, 6'd0, '0, 1'b1);
        for (n = 1; n <= 70; n++) begin
            if (n == 6) applyStimulus(1'b1, 18'h00777, 1'b1, 6'd0, 16'hFFFF, 1'b1);
            else idleCycle(1'b1);
        end
        checkOutput("s4_write_count", 32'(dut_writes - writes0), 32'd64);
        applyStimulus(1'b1, 18'h00000, 1'b0, 6'd0, '0, 1'b1);
        checkOutput("s4_buf0_kept", 32'(sram_data), 32'h1000);
        for (n = 1; n <= 70; n++) idleCycle(1'b1);

        $display("[TB] reset during transfer");
        applyStimulus(1'b1, 18'h00500, 1'b0, 6'd0, '0, 1'b1);
        for (n = 1; n <= 20; n++) idleCycle(1'b1);
        checkOutput("s5_k20_addr", 32'(sram_addr), 32'h00514);
        doReset();
        cnt = 0;
        for (n = 1; n <= 70; n++) begin
            if (done || sram_we) cnt++;
            idleCycle(1'b1);
        end
        checkOutput("s5_no_activity", 32'(cnt), 32'd0);
        applyStimulus(1'b1, 18'h00777, 1'b0, 6'd0, '0, 1'b1);
        checkOutput("s5_restart_addr", 32'(sram_addr), 32'h00777);
        checkOutput("s5_restart_data", 32'(sram_data), 32'h1000);
        for (n = 1; n <= 70; n++) idleCycle(1'b1);

        $display("[TB] back-to-back starts");
        applyStimulus(1'b1, 18'h00040, 1'b0, 6'd0, '0, 1'b1);
        prev_we = 1'b0; rise1 = -1; rise2 = -1;
        for (n = 1; n <= 140; n++) begin
            if (sram_we && !prev_we) begin
                if (rise1 < 0) rise1 = n;
                else if (rise2 < 0) rise2 = n;
            end
            prev_we = sram_we;
            applyStimulus(1'b1, 18'h00040, 1'b0, 6'd0, '0, 1'b1);
        end
        checkOutput("s6_first_we", 32'(rise1), 32'd1);
        checkOutput("s6_second_we", 32'(rise2), 32'd67);
        for (n = 1; n <= 140; n++) idleCycle(1'b1);

        $display("[TB] random phase");
        for (int i = 0; i < 2000; i++) begin
            applyStimulus(($urandom % 20) == 0, AW'($urandom), 1'($urandom),
                          6'($urandom), DW'($urandom), ($urandom % 4) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
